store_narrow_serializer: RTL

- Narrowing counterpart of the immediate/load widening path: takes a 32-bit store operand and writes it as byte beats to a byte-wide data memory.
- Opcode selects sb/sh/sw (1/2/4 bytes).
- Sits between the execute stage and the byte-wide data RAM.
- Stalls the CPU via busy until the store completes.

---
 rtl/store_narrow_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/store_narrow_serializer.sv
// Byte-beat store serializer: splits sb/sh/sw operands into byte writes.
// Define STORE_LE_EN for little-endian beat order (default big-endian).
module store_narrow_serializer #(
    parameter int          ADDR_W = 32,
    parameter logic [5:0]  OP_SB  = 6'd40,
    parameter logic [5:0]  OP_SH  = 6'd41,
    parameter logic [5:0]  OP_SW  = 6'd43
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_byte,
    input  logic              mem_ready
);

`ifdef STORE_LE_EN
    localparam bit LE = 1'b1;
`else
    localparam bit LE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_l;
    logic [31:0]       wdata_l;
    logic [1:0]        last_l;
    logic [1:0]        k;
    logic [1:0]        kn;
    logic              dec_ok;
    logic [1:0]        dec_last;

    assign kn = k + 2'd1;

    // For n in {1,2,4}, (n-1)-k equals (n-1)^k, giving the BE byte lane.
    function automatic logic [7:0] pick(
        input logic [31:0] d,
        input logic [1:0]  last,
        input logic [1:0]  kk
    );
        logic [1:0] idx;
        idx = LE ? kk : (last ^ kk);
        return d[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        dec_ok   = 1'b0;
        dec_last = 2'd0;
        unique case (1'b1)
            (opcode == OP_SB): begin
                dec_ok   = 1'b1;
                dec_last = 2'd0;
            end
            (opcode == OP_SH): begin
                dec_ok   = ~addr[0];
                dec_last = 2'd1;
            end
            (opcode == OP_SW): begin
                dec_ok   = (addr[1:0] == 2'b00);
                dec_last = 2'd3;
            end
            default: begin
                dec_ok   = 1'b0;
                dec_last = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_byte <= 8'h00;
            addr_l   <= '0;
            wdata_l  <= 32'h0;
            last_l   <= 2'd0;
            k        <= 2'd0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    done   <= 1'b0;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                    if (start) begin
                        addr_l  <= addr;
                        wdata_l <= wdata;
                        last_l  <= dec_last;
                        k       <= 2'd0;
                        busy    <= 1'b1;
                        if (dec_ok) begin
                            state    <= WRITE;
                            mem_we   <= 1'b1;
                            mem_addr <= addr;
                            mem_byte <= pick(wdata, dec_last, 2'd0);
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (k == last_l) begin
                            mem_we <= 1'b0;
                            done   <= 1'b1;
                            state  <= FIN;
                        end else begin
                            k        <= kn;
                            mem_addr <= addr_l + {{(ADDR_W-2){1'b0}}, kn};
                            mem_byte <= pick(wdata_l, last_l, kn);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
